// File: rtl/lcd_spi_pkg.sv
// Shared types and constants for the LCD SPI init sequencer: state encoding,
// 17-bit init-table entry layout and the built-in default init table.
package lcd_spi_pkg;

  localparam int unsigned WORD_W       = 16;
  localparam int unsigned ENTRY_W      = WORD_W + 1;
  localparam int unsigned DELAY_UNIT   = 1024;
  localparam int unsigned MAX_PAUSE    = (2 ** WORD_W - 1) * DELAY_UNIT;
  // Lead-in low half, 16 high/low pairs, trailing low half before CS rises.
  localparam int unsigned HALF_PERIODS = 2 * WORD_W + 2;

  typedef enum logic [2:0] {
    StIdle,
    StPwrWait,
    StLoad,
    StShift,
    StGap,
    StDelay,
    StDone
  } state_e;

  typedef struct packed {
    logic              is_pause;
    logic [WORD_W-1:0] data;
  } entry_t;

  // Panel bring-up: soft reset, sleep-out, pixel format, display on; unused slots are NOPs.
  function automatic entry_t default_entry(input int unsigned idx);
    logic [ENTRY_W-1:0] e;
    case (idx)
      0:       e = 17'h00001;
      1:       e = 17'h10078;
      2:       e = 17'h00011;
      3:       e = 17'h10078;
      4:       e = 17'h0003A;
      5:       e = 17'h00155;
      6:       e = 17'h00036;
      7:       e = 17'h00100;
      8:       e = 17'h00021;
      9:       e = 17'h00013;
      10:      e = 17'h1000A;
      11:      e = 17'h00029;
      12:      e = 17'h10014;
      default: e = 17'h00000;
    endcase
    return entry_t'(e);
  endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Synchronous init-table ROM: entry appears one clock after the index is presented.
// Out-of-range indices read back as zero.
module lcd_init_rom
  import lcd_spi_pkg::*;
#(
  parameter int unsigned                  NUM_WORDS = 32,
  parameter int unsigned                  IDX_W     = $clog2(NUM_WORDS + 1),
  parameter bit                           USE_TABLE = 1'b0,
  parameter logic [NUM_WORDS*ENTRY_W-1:0] TABLE     = '0
) (
  input  logic             clk_50,
  input  logic [IDX_W-1:0] index,
  output entry_t           entry
);

  entry_t lookup;

  always_comb begin
    lookup = '0;
    if (32'(index) < NUM_WORDS) begin
      if (USE_TABLE) begin
        lookup = entry_t'(TABLE[32'(index)*ENTRY_W +: ENTRY_W]);
      end else begin
        lookup = default_entry(32'(index));
      end
    end
  end

  always_ff @(posedge clk_50) begin
    entry <= lookup;
  end

endmodule

// File: rtl/lcd_spi_init_seq.sv
// Power-up SPI init sequencer for an LCD panel: waits PWR_DLY, then plays the init table
// as 16-bit SPI words (mode 0, MSB first) and timed pauses. Define LCD_SPI_AUTOSTART_EN to start
// automatically after reset instead of on the start pulse.
module lcd_spi_init_seq
  import lcd_spi_pkg::*;
#(
  parameter int unsigned                  CLK_DIV   = 8,
  parameter int unsigned                  GAP_CYC   = 16,
  parameter int unsigned                  PWR_DLY   = 500000,
  parameter int unsigned                  NUM_WORDS = 32,
  parameter bit                           USE_TABLE = 1'b0,
  parameter logic [NUM_WORDS*ENTRY_W-1:0] TABLE     = '0
) (
  input  logic clk_50,
  input  logic reset_n,
  input  logic start,
  output logic spi_sclk,
  output logic spi_cs_n,
  output logic spi_sdi,
  output logic busy,
  output logic done
);

  localparam int unsigned IDX_W    = $clog2(NUM_WORDS + 1);
  localparam int unsigned DIV_W    = $clog2(CLK_DIV);
  localparam int unsigned HP_W     = $clog2(HALF_PERIODS);
  localparam int unsigned MAX_A    = (PWR_DLY > MAX_PAUSE) ? PWR_DLY : MAX_PAUSE;
  localparam int unsigned MAX_WAIT = (GAP_CYC > MAX_A) ? GAP_CYC : MAX_A;
  localparam int unsigned CNT_W    = $clog2(MAX_WAIT);

  localparam logic [CNT_W-1:0] PWR_LOAD = CNT_W'((PWR_DLY > 0) ? PWR_DLY - 1 : 0);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [HP_W-1:0]  HP_LAST  = HP_W'(HALF_PERIODS - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [HP_W-1:0]     hp_q, hp_d;
  logic [WORD_W-1:0]   sr_q, sr_d;
  logic                sclk_q, sclk_d;
  logic                cs_n_q, cs_n_d;
  logic                sdi_q, sdi_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                advance;
  logic                go;
  logic [CNT_W-1:0]    pause_load;
  entry_t              rom_entry;

`ifdef LCD_SPI_AUTOSTART_EN
  assign go = 1'b1;
`else
  assign go = start;
`endif

  // ROM is addressed with the next index so the entry for idx_q is ready in LOAD.
  lcd_init_rom #(
    .NUM_WORDS (NUM_WORDS),
    .IDX_W     (IDX_W),
    .USE_TABLE (USE_TABLE),
    .TABLE     (TABLE)
  ) u_rom (
    .clk_50 (clk_50),
    .index  (idx_d),
    .entry  (rom_entry)
  );

  // A zero-length pause still spends one cycle in DELAY.
  assign pause_load = (rom_entry.data == '0) ? '0 :
                      CNT_W'(32'(rom_entry.data) * DELAY_UNIT - 32'd1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    hp_d    = hp_q;
    sr_d    = sr_q;
    advance = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (go) begin
          state_d = StPwrWait;
          cnt_d   = PWR_LOAD;
        end
      end
      StPwrWait: begin
        if (cnt_q == '0) begin
          state_d = StLoad;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StLoad: begin
        if (rom_entry.is_pause) begin
          state_d = StDelay;
          cnt_d   = pause_load;
        end else begin
          state_d = StShift;
          sr_d    = rom_entry.data;
          div_d   = '0;
          hp_d    = '0;
        end
      end
      StShift: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (hp_q == HP_LAST) begin
            state_d = StGap;
            cnt_d   = GAP_LOAD;
          end else begin
            hp_d = hp_q + 1'b1;
            // Leaving a high half: falling edge, present the next bit.
            if (hp_q[0]) begin
              sr_d = {sr_q[WORD_W-2:0], 1'b0};
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StGap, StDelay: begin
        if (cnt_q == '0) begin
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
      end
      default: state_d = StIdle;
    endcase

    if (advance) begin
      idx_d   = idx_q + 1'b1;
      state_d = (32'(idx_d) == NUM_WORDS) ? StDone : StLoad;
    end

    // Outputs are registered copies of the next-state decode, so they line up with state_q.
    cs_n_d = (state_d != StShift);
    sclk_d = (state_d == StShift) && hp_d[0] && (hp_d != HP_LAST);
    sdi_d  = (state_d == StShift) && sr_d[WORD_W-1];
    busy_d = !(state_d inside {StIdle, StDone});
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      hp_q    <= '0;
      sr_q    <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      sdi_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      hp_q    <= hp_d;
      sr_q    <= sr_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      sdi_q   <= sdi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign spi_sclk = sclk_q;
  assign spi_cs_n = cs_n_q;
  assign spi_sdi  = sdi_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_lcd_spi_init_seq.sv
// Directed bench for lcd_spi_init_seq: one word, word/pause/word, and zero-pause tables.
module tb_lcd_spi_init_seq;

  logic clk_50 = 1'b0;
  always #5 clk_50 = ~clk_50;

  logic reset_n;
  logic start_a, start_b, start_c;
  logic sclk_a, cs_a, sdi_a, busy_a, done_a;
  logic sclk_b, cs_b, sdi_b, busy_b, done_b;
  logic sclk_c, cs_c, sdi_c, busy_c, done_c;

  int n_tests = 0;
  int n_fail  = 0;

  lcd_spi_init_seq #(
    .CLK_DIV (2), .GAP_CYC (3), .PWR_DLY (4), .NUM_WORDS (1),
    .USE_TABLE (1'b1), .TABLE (17'h07A5C)
  ) u_a (
    .clk_50 (clk_50), .reset_n (reset_n), .start (start_a),
    .spi_sclk (sclk_a), .spi_cs_n (cs_a), .spi_sdi (sdi_a), .busy (busy_a), .done (done_a)
  );

  lcd_spi_init_seq #(
    .CLK_DIV (2), .GAP_CYC (3), .PWR_DLY (4), .NUM_WORDS (3),
    .USE_TABLE (1'b1), .TABLE ({17'h00155, 17'h10002, 17'h00A0F})
  ) u_b (
    .clk_50 (clk_50), .reset_n (reset_n), .start (start_b),
    .spi_sclk (sclk_b), .spi_cs_n (cs_b), .spi_sdi (sdi_b), .busy (busy_b), .done (done_b)
  );

  lcd_spi_init_seq #(
    .CLK_DIV (2), .GAP_CYC (3), .PWR_DLY (4), .NUM_WORDS (1),
    .USE_TABLE (1'b1), .TABLE (17'h10000)
  ) u_c (
    .clk_50 (clk_50), .reset_n (reset_n), .start (start_c),
    .spi_sclk (sclk_c), .spi_cs_n (cs_c), .spi_sdi (sdi_c), .busy (busy_c), .done (done_c)
  );

  // Line monitors, sampled on the falling clock edge.
  logic [15:0] bits_a;
  int          rises_a, cs_low_a;
  logic        sclk_prev_a;
  logic [31:0] bits_b;
  int          rises_b, falls_b, gap_hi_b;
  logic        gap_sclk_b, sclk_prev_b, cs_prev_b;
  int          cs_low_c;

  always @(negedge clk_50) begin
    if (!reset_n) begin
      bits_a <= '0; rises_a <= 0; cs_low_a <= 0; sclk_prev_a <= 1'b0;
      bits_b <= '0; rises_b <= 0; falls_b <= 0; gap_hi_b <= 0;
      gap_sclk_b <= 1'b0; sclk_prev_b <= 1'b0; cs_prev_b <= 1'b1; cs_low_c <= 0;
    end else begin
      sclk_prev_a <= sclk_a;
      if (sclk_a && !sclk_prev_a) begin
        bits_a  <= {bits_a[14:0], sdi_a};
        rises_a <= rises_a + 1;
      end
      if (!cs_a) cs_low_a <= cs_low_a + 1;

      sclk_prev_b <= sclk_b;
      cs_prev_b   <= cs_b;
      if (sclk_b && !sclk_prev_b) begin
        bits_b  <= {bits_b[30:0], sdi_b};
        rises_b <= rises_b + 1;
      end
      if (cs_prev_b && !cs_b) falls_b <= falls_b + 1;
      if (falls_b == 1 && cs_b) begin
        gap_hi_b <= gap_hi_b + 1;
        if (sclk_b) gap_sclk_b <= 1'b1;
      end

      if (!cs_c) cs_low_c <= cs_low_c + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_50);
    #1;
  endtask

  typedef struct {
    string name;
    logic  start;
    int    adv;
    logic  cs_n;
    logic  sclk;
    logic  sdi;
    logic  busy;
    logic  done;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    // Edge counts are relative to the edge that samples start (e0).
    vecs[0]  = '{"pwr_enter",    1'b1, 1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{"load",         1'b0, 4,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{"cs_fall",      1'b0, 1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{"rise0",        1'b0, 2,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{"restart_shift",1'b1, 1,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{"fall0",        1'b0, 1,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{"rise1",        1'b0, 2,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{"gap_enter",    1'b0, 62, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{"gap_end",      1'b0, 2,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{"done_set",     1'b0, 1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{"start_in_done",1'b1, 5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    reset_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    step(3);
    check("rst_cs_a",   32'(cs_a),   32'd1);
    check("rst_sclk_a", 32'(sclk_a), 32'd0);
    check("rst_sdi_a",  32'(sdi_a),  32'd0);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_done_a", 32'(done_a), 32'd0);
    check("rst_cs_b",   32'(cs_b),   32'd1);
    check("rst_busy_c", 32'(busy_c), 32'd0);
    reset_n = 1'b1;

`ifdef LCD_SPI_AUTOSTART_EN
    step(1);
    check("auto_busy_a", 32'(busy_a), 32'd1);
    check("auto_busy_b", 32'(busy_b), 32'd1);
    cyc = 0;
    while (!done_a && cyc < 300) begin step(1); cyc++; end
    check("auto_done_a", 32'(done_a), 32'd1);
    check("auto_bits_a", 32'(bits_a), 32'h7A5C);
    check("auto_cs_low_a", 32'(cs_low_a), 32'd68);
`else
    step(10);
    check("idle_no_start", 32'(busy_a), 32'd0);

    for (int i = 0; i < 11; i++) begin
      start_a = vecs[i].start;
      step(vecs[i].adv);
      check({vecs[i].name, "_cs"},   32'(cs_a),   32'(vecs[i].cs_n));
      check({vecs[i].name, "_sclk"}, 32'(sclk_a), 32'(vecs[i].sclk));
      check({vecs[i].name, "_sdi"},  32'(sdi_a),  32'(vecs[i].sdi));
      check({vecs[i].name, "_busy"}, 32'(busy_a), 32'(vecs[i].busy));
      check({vecs[i].name, "_done"}, 32'(done_a), 32'(vecs[i].done));
    end
    start_a = 1'b0;
    check("a_bits",   32'(bits_a),   32'h7A5C);
    check("a_rises",  32'(rises_a),  32'd16);
    check("a_cs_low", 32'(cs_low_a), 32'd68);

    // Word, 2*1024-cycle pause, word.
    start_b = 1'b1;
    step(1);
    start_b = 1'b0;
    cyc = 0;
    while (!done_b && cyc < 5000) begin step(1); cyc++; end
    check("b_done",     32'(done_b),     32'd1);
    check("b_words",    32'(falls_b),    32'd2);
    check("b_rises",    32'(rises_b),    32'd32);
    check("b_bits",     bits_b,          32'h0A0F_0155);
    // Gap (3) + pause LOAD (1) + pause (2048) + next word LOAD (1).
    check("b_cs_high",  32'(gap_hi_b),   32'd2053);
    check("b_sclk_low", 32'(gap_sclk_b), 32'd0);

    // Zero-length pause as the only entry.
    start_c = 1'b1;
    step(1);
    start_c = 1'b0;
    step(4);
    check("c_load_busy", 32'(busy_c), 32'd1);
    step(1);
    check("c_delay_done", 32'(done_c), 32'd0);
    check("c_delay_cs",   32'(cs_c),   32'd1);
    step(1);
    check("c_done",      32'(done_c),   32'd1);
    check("c_busy_drop", 32'(busy_c),   32'd0);
    check("c_no_word",   32'(cs_low_c), 32'd0);

    // Abort mid-word at bit 7, then a full restart.
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(1);
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    step(39);
    check("bit7_sclk", 32'(sclk_a), 32'd1);
    check("bit7_cs",   32'(cs_a),   32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_cs",   32'(cs_a),   32'd1);
    check("abort_sclk", 32'(sclk_a), 32'd0);
    check("abort_busy", 32'(busy_a), 32'd0);
    step(2);
    reset_n = 1'b1;
    step(1);
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    cyc = 0;
    while (!done_a && cyc < 200) begin step(1); cyc++; end
    check("restart_latency", 32'(cyc),      32'd76);
    check("restart_bits",    32'(bits_a),   32'h7A5C);
    check("restart_rises",   32'(rises_a),  32'd16);
    check("restart_cs_low",  32'(cs_low_a), 32'd68);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
